// File: rtl/bcd_digit_counter.sv
// Multi-digit BCD up/down counter with prescaled enable, parallel load and a
// time-multiplexed digit output. Define BCD_SAT_EN to saturate instead of wrapping.
module bcd_digit_counter #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1,
    localparam int SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic [SW-1:0]         scan_idx,
    output logic                  w,
    output logic                  x,
    output logic                  y,
    output logic                  z
);

    localparam logic [7:0]    PS_LAST  = 8'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(DIGITS - 1);

    logic [7:0]           presc_r;
    logic [7:0]           presc_nxt_s;
    logic [4*DIGITS-1:0]  bcd_r;
    logic [4*DIGITS-1:0]  bcd_nxt_s;
    logic [4*DIGITS-1:0]  step_val_s;
    logic [4*DIGITS-1:0]  load_clean_s;
    logic                 wrap_s;
    logic                 chain_s;
    logic                 carry_r;
    logic                 carry_nxt_s;
    logic [SW-1:0]        scan_r;
    logic [SW-1:0]        scan_nxt_s;
    logic [3:0]           sel_digit_s;

    function automatic logic [3:0] sanitize(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd0;
        end else begin
            return d;
        end
    endfunction

    // Returns {carry_out, digit}; a stray code above 9 is treated as 9.
    function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic cin);
        if (!cin) begin
            return {1'b0, d};
        end else if (d >= 4'd9) begin
            return {1'b1, 4'd0};
        end else begin
            return {1'b0, d + 4'd1};
        end
    endfunction

    // Returns {borrow_out, digit}.
    function automatic logic [4:0] digit_dec(input logic [3:0] d, input logic bin);
        if (!bin) begin
            return {1'b0, d};
        end else if (d == 4'd0) begin
            return {1'b1, 4'd9};
        end else if (d > 4'd9) begin
            return {1'b0, 4'd9};
        end else begin
            return {1'b0, d - 4'd1};
        end
    endfunction

    // Ripple the +1/-1 through all digits and sanitise the load value.
    always_comb begin
        chain_s      = 1'b1;
        step_val_s   = bcd_r;
        load_clean_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (up) begin
                {chain_s, step_val_s[4*i +: 4]} = digit_inc(bcd_r[4*i +: 4], chain_s);
            end else begin
                {chain_s, step_val_s[4*i +: 4]} = digit_dec(bcd_r[4*i +: 4], chain_s);
            end
            load_clean_s[4*i +: 4] = sanitize(load_val[4*i +: 4]);
        end
        wrap_s = chain_s;
    end

    // Load beats step; the prescaler only moves on enabled, non-load cycles.
    always_comb begin
        presc_nxt_s = presc_r;
        bcd_nxt_s   = bcd_r;
        carry_nxt_s = 1'b0;
        if (load) begin
            presc_nxt_s = 8'd0;
            bcd_nxt_s   = load_clean_s;
        end else if (en) begin
            if (presc_r >= PS_LAST) begin
                presc_nxt_s = 8'd0;
                carry_nxt_s = wrap_s;
`ifdef BCD_SAT_EN
                if (wrap_s) begin
                    bcd_nxt_s = bcd_r;
                end else begin
                    bcd_nxt_s = step_val_s;
                end
`else
                bcd_nxt_s = step_val_s;
`endif
            end else begin
                presc_nxt_s = presc_r + 8'd1;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Free-running digit scan index.
    always_comb begin
        scan_nxt_s = scan_r;
        if (scan_r >= SCAN_MAX) begin
            scan_nxt_s = '0;
        end else begin
            scan_nxt_s = scan_r + SW'(1);
        end
    end

    // Digit mux; indices beyond DIGITS-1 never occur but decode to zero.
    always_comb begin
        sel_digit_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_r == SW'(i)) begin
                sel_digit_s = bcd_r[4*i +: 4];
            end else begin
                sel_digit_s = sel_digit_s;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 8'd0;
            bcd_r   <= '0;
            carry_r <= 1'b0;
            scan_r  <= '0;
        end else begin
            presc_r <= presc_nxt_s;
            bcd_r   <= bcd_nxt_s;
            carry_r <= carry_nxt_s;
            scan_r  <= scan_nxt_s;
        end
    end

    assign bcd          = bcd_r;
    assign carry        = carry_r;
    assign scan_idx     = scan_r;
    assign {w, x, y, z} = sel_digit_s;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench for bcd_digit_counter: one PRESCALE=1 and one PRESCALE=4 instance.
module tb_bcd_digit_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [7:0] a_lv = 8'h00;
    logic [7:0] a_bcd;
    logic       a_carry, a_w, a_x, a_y, a_z;
    logic [0:0] a_scan;
    logic       b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
    logic [7:0] b_lv = 8'h00;
    logic [7:0] b_bcd;
    logic       b_carry, b_w, b_x, b_y, b_z;
    logic [0:0] b_scan;

    bcd_digit_counter #(.DIGITS(2), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
        .bcd(a_bcd), .carry(a_carry), .scan_idx(a_scan),
        .w(a_w), .x(a_x), .y(a_y), .z(a_z)
    );

    bcd_digit_counter #(.DIGITS(2), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
        .bcd(b_bcd), .carry(b_carry), .scan_idx(b_scan),
        .w(b_w), .x(b_x), .y(b_y), .z(b_z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         dut;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rel_cyc = 0;

    localparam int K_BCD = 0, K_CARRY = 1, K_SCAN = 2, K_MUX = 3;

    task automatic push(input int dly, input int dut, input int kind,
                        input logic [7:0] val, input string name);
        exp_t e;
        int   pos;
        e.cyc  = cyc + dly;
        e.dut  = dut;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        pos    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    // Expected {scan_idx, w,x,y,z} for A holding 0x47; scan phase counted from reset release.
    task automatic push_mux(input int dly);
        int s;
        s = (cyc + dly - rel_cyc) % 2;
        push(dly, 0, K_MUX, (s == 1) ? 8'h14 : 8'h07, "mux47");
    endtask

    function automatic logic [7:0] actual(input int dut, input int kind);
        if (dut == 0) begin
            case (kind)
                K_BCD:   return a_bcd;
                K_CARRY: return {7'd0, a_carry};
                K_SCAN:  return {7'd0, a_scan};
                default: return {3'd0, a_scan, a_w, a_x, a_y, a_z};
            endcase
        end else begin
            case (kind)
                K_BCD:   return b_bcd;
                K_CARRY: return {7'd0, b_carry};
                K_SCAN:  return {7'd0, b_scan};
                default: return {3'd0, b_scan, b_w, b_x, b_y, b_z};
            endcase
        end
    endfunction

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.dut, e.kind);
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h expected %h (due cycle %0d)",
                         e.name, cyc, act, e.val, e.cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        tick();
        push(0, 0, K_BCD, 8'h00, "rst_a_bcd");
        push(0, 0, K_CARRY, 8'h00, "rst_a_carry");
        push(0, 0, K_SCAN, 8'h00, "rst_a_scan");
        push(0, 1, K_BCD, 8'h00, "rst_b_bcd");
        tick();
        rst = 1'b0;
        rel_cyc = cyc;
        push(0, 0, K_SCAN, 8'h00, "scan0");
        push(1, 0, K_SCAN, 8'h01, "scan1");
        push(2, 0, K_SCAN, 8'h00, "scan2");
        push(1, 1, K_SCAN, 8'h01, "scan_b1");
        tick(3);

        // Asynchronous reset mid-operation
        a_load = 1'b1; a_lv = 8'h37;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h37, "load37");
        tick();
        rst = 1'b1;
        push(0, 0, K_BCD, 8'h00, "async_rst_bcd");
        push(0, 0, K_CARRY, 8'h00, "async_rst_carry");
        push(0, 0, K_SCAN, 8'h00, "async_rst_scan");
        tick();
        rst = 1'b0;
        rel_cyc = cyc;
        push(0, 0, K_SCAN, 8'h00, "rel_scan0");
        push(1, 0, K_SCAN, 8'h01, "rel_scan1");
        push(2, 0, K_SCAN, 8'h00, "rel_scan2");
        push(3, 0, K_SCAN, 8'h01, "rel_scan3");
        tick(4);

        // Prescaled count with an enable gap (B, PRESCALE=4)
        b_load = 1'b1; b_lv = 8'h00; b_en = 1'b1; b_up = 1'b1;
        tick();
        b_load = 1'b0;
        push(0, 1, K_BCD, 8'h00, "ps_start");
        push(3, 1, K_BCD, 8'h00, "ps_before_step");
        push(4, 1, K_BCD, 8'h01, "ps_step");
        push(4, 1, K_CARRY, 8'h00, "ps_step_carry");
        tick(4);
        push(0, 1, K_BCD, 8'h01, "gap_start");
        push(6, 1, K_BCD, 8'h01, "gap_hold");
        push(7, 1, K_BCD, 8'h02, "gap_step");
        tick(2);
        b_en = 1'b0;
        tick(3);
        b_en = 1'b1;
        tick(2);

        // Load on the step cycle wins and sanitises the low nibble
        tick(3);
        push(0, 1, K_BCD, 8'h02, "pre_load");
        push(1, 1, K_BCD, 8'h50, "load_5c");
        push(1, 1, K_CARRY, 8'h00, "load_carry");
        push(4, 1, K_BCD, 8'h50, "load_hold");
        push(5, 1, K_BCD, 8'h51, "load_next_step");
        b_load = 1'b1; b_lv = 8'h5C;
        tick();
        b_load = 1'b0;
        tick(4);
        b_en = 1'b0;

        // Up count through the top (A, PRESCALE=1)
        a_load = 1'b1; a_lv = 8'h98; a_en = 1'b1; a_up = 1'b1;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h98, "up_98");
        push(0, 0, K_CARRY, 8'h00, "up_98_carry");
        push(1, 0, K_BCD, 8'h99, "up_99");
        push(1, 0, K_CARRY, 8'h00, "up_99_carry");
`ifdef BCD_SAT_EN
        push(2, 0, K_BCD, 8'h99, "up_sat");
        push(2, 0, K_CARRY, 8'h01, "up_sat_carry");
        push(3, 0, K_BCD, 8'h99, "up_sat2");
        push(3, 0, K_CARRY, 8'h01, "up_sat2_carry");
`else
        push(2, 0, K_BCD, 8'h00, "up_wrap");
        push(2, 0, K_CARRY, 8'h01, "up_wrap_carry");
        push(3, 0, K_BCD, 8'h01, "up_01");
        push(3, 0, K_CARRY, 8'h00, "up_01_carry");
`endif
        tick(3);

        // Down count with borrow
        a_load = 1'b1; a_lv = 8'h10; a_up = 1'b0;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h10, "dn_10");
        push(1, 0, K_BCD, 8'h09, "dn_09");
        push(2, 0, K_BCD, 8'h08, "dn_08");
        push(2, 0, K_CARRY, 8'h00, "dn_08_carry");
        tick(2);

        // Down through zero
        a_load = 1'b1; a_lv = 8'h00;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h00, "dn_00");
        push(0, 0, K_CARRY, 8'h00, "dn_00_carry");
`ifdef BCD_SAT_EN
        push(1, 0, K_BCD, 8'h00, "dn_sat");
        push(1, 0, K_CARRY, 8'h01, "dn_sat_carry");
        push(2, 0, K_BCD, 8'h00, "dn_sat2");
        push(2, 0, K_CARRY, 8'h01, "dn_sat2_carry");
`else
        push(1, 0, K_BCD, 8'h99, "dn_wrap");
        push(1, 0, K_CARRY, 8'h01, "dn_wrap_carry");
        push(2, 0, K_BCD, 8'h98, "dn_98");
        push(2, 0, K_CARRY, 8'h00, "dn_98_carry");
`endif
        tick(2);
        a_en = 1'b0;

        // Digit mux
        a_load = 1'b1; a_lv = 8'h47;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h47, "mux_bcd");
        push_mux(0);
        push_mux(1);
        push_mux(2);
        push_mux(3);
        tick(4);

        // High nibble out of range loads as zero
        a_load = 1'b1; a_lv = 8'hF3;
        tick();
        a_load = 1'b0;
        push(0, 0, K_BCD, 8'h03, "load_f3");
        tick(2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
